// File: rtl/pulse_voice.sv
// Pulse-wave voice: phase accumulator, boundary-synchronous duty reload, envelope gating, 2-cycle output pipeline.
// Optional build macro PULSE_VOICE_ENV_RAMP_EN slews the envelope by at most 8 per strobe.
module pulse_voice #(
    parameter int PHASE_WIDTH = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_sample_stb,
    input  logic [PHASE_WIDTH-1:0] i_phase_delta,
    input  logic [7:0]             i_top,
    input  logic                   i_top_valid,
    input  logic [8:0]             i_envelope,
    output logic [9:0]             o_sample,
    output logic                   o_sample_valid
);

    logic [PHASE_WIDTH-1:0] r_phase;
    logic [7:0]             r_duty;
    logic [7:0]             r_pending_top;
    logic                   r_pending_flag;
    logic [8:0]             r_env;
    logic                   r_mute;
    logic                   r_s1_valid;

    logic [PHASE_WIDTH:0]   w_sum;
    logic                   w_wrap;
    logic [8:0]             w_env_next;
    logic                   w_high;
    logic [9:0]             w_mag;
    logic [9:0]             w_level;

    assign w_sum  = {1'b0, r_phase} + {1'b0, i_phase_delta};
    assign w_wrap = i_sample_stb & w_sum[PHASE_WIDTH];

`ifdef PULSE_VOICE_ENV_RAMP_EN
    // Slew toward the new target so note-on envelope jumps do not click.
    always_comb begin
        w_env_next = r_env;
        if (i_envelope > r_env) begin
            w_env_next = ((i_envelope - r_env) > 9'd8) ? (r_env + 9'd8) : i_envelope;
        end else if (i_envelope < r_env) begin
            w_env_next = ((r_env - i_envelope) > 9'd8) ? (r_env - 9'd8) : i_envelope;
        end
    end
`else
    assign w_env_next = i_envelope;
`endif

    assign w_high  = (r_phase[PHASE_WIDTH-1 -: 8] < r_duty);
    assign w_mag   = {1'b0, r_env};
    assign w_level = r_mute ? 10'd0 : (w_high ? w_mag : (~w_mag + 10'd1));

    // Stage 1: phase advance, mute and envelope capture on each strobe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_phase    <= '0;
            r_mute     <= 1'b1;
            r_env      <= 9'd0;
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= i_sample_stb;
            if (i_sample_stb) begin
                r_phase <= w_sum[PHASE_WIDTH-1:0];
                r_mute  <= (i_phase_delta == '0);
                r_env   <= w_env_next;
            end
        end
    end

    // Duty only changes on a period wrap; a top arriving with the wrap wins over the pending one.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_duty         <= 8'h80;
            r_pending_top  <= 8'h80;
            r_pending_flag <= 1'b0;
        end else begin
            if (i_top_valid) begin
                r_pending_top <= i_top;
            end
            if (w_wrap && i_top_valid) begin
                r_duty         <= i_top;
                r_pending_flag <= 1'b0;
            end else if (w_wrap && r_pending_flag) begin
                r_duty         <= r_pending_top;
                r_pending_flag <= 1'b0;
            end else if (i_top_valid) begin
                r_pending_flag <= 1'b1;
            end
        end
    end

    // Stage 2: compare and output register; the sample holds between valid pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_sample       <= 10'd0;
            o_sample_valid <= 1'b0;
        end else begin
            o_sample_valid <= r_s1_valid;
            if (r_s1_valid) begin
                o_sample <= w_level;
            end
        end
    end

endmodule
